sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller host port between two bus masters: port A
//  (CPU data/instruction bus) and port B (DMA/video). Arbitrates per transfer,
//  muxes address/data/control to the controller and returns data/ack to the winner.
//  Sits between the bus fabric and the SDRAM controller; holds no data buffering.
// PARAMETERS
//  ADDR_WIDTH     25  host word address is [ADDR_WIDTH:1]
//  FIXED_PRIORITY 0   0: round-robin; 1: port B always wins on contention
// PORTS
//  clk            in  1   clock
//  reset          in  1   asynchronous, active-high reset
//  a_access       in  1   port A request; held until a_ack
//  a_addr         in  ADDR_WIDTH  port A word address [ADDR_WIDTH:1]
//  a_wdata        in  16  port A write data
//  a_wr_en        in  1   port A write (1) / read (0)
//  a_bytesel      in  2   port A byte enables
//  a_lock         in  1   port A locked-sequence request (see CONFIGURATION)
//  a_rdata        out 16  port A read data, valid with a_ack, else 0
//  a_ack          out 1   port A one-cycle completion pulse
//  b_access/b_addr/b_wdata/b_wr_en/b_bytesel/b_rdata/b_ack: as port A
//  q_access       out 1   to controller cs and data_m_access
//  q_addr         out ADDR_WIDTH  to controller h_addr
//  q_wdata        out 16  to controller h_wdata
//  q_wr_en        out 1   to controller h_wr_en
//  q_bytesel      out 2   to controller h_bytesel
//  q_rdata        in  16  from controller h_rdata (0 except completion cycle)
//  q_compl        in  1   from controller h_compl (one-cycle pulse)
//  q_config_done  in  1   from controller h_config_done
// BEHAVIOUR
//  - States: IDLE, GRANT_A, GRANT_B (registered). Reset: IDLE, last_grant=B,
//    all outputs 0. Async reset mid-transfer abandons it; no ack is issued.
//  - IDLE: no grant while q_config_done=0. Else sample a_access/b_access:
//    one requester -> grant it; both -> FIXED_PRIORITY=1: B; else the port
//    that is not last_grant. Grant takes effect next edge (1-cycle arb latency).
//  - GRANT_x: q_access = x_access; q_addr/q_wdata/q_wr_en/q_bytesel
//    combinationally muxed from port x. Non-granted port: ack=0, rdata=0.
//    In IDLE, q_* all 0.
//  - x_ack = q_compl & GRANT_x; x_rdata = GRANT_x ? q_rdata : 0 (same cycle).
//  - On q_compl in GRANT_x: next state IDLE, last_grant <= x. q_compl in IDLE
//    is ignored (no ack generated).
//  - Requester contract: hold access/addr/data stable until ack; may re-assert
//    access the cycle after ack. Access dropped before ack while granted: grant
//    held until q_compl (controller is committed); ack still pulses.
//  - Back-to-back: min ack-to-next-grant spacing 1 IDLE cycle; with both
//    requesting continuously, round-robin alternates A,B,A,B.
// CONFIGURATION
//  SDRAM_ARB_LOCK_EN defined: if a_lock=1 on the a_ack cycle, stay in GRANT_A
//    (skip IDLE) and serve A's next access regardless of b_access; lock ends
//    on an a_ack with a_lock=0. last_grant=A while locked.
//  Not defined: a_lock ignored; every transfer re-arbitrates via IDLE.
// TESTING
//  1. q_config_done=0, a_access=1 for 20 cycles -> q_access=0; raise done ->
//     GRANT_A next edge, q_addr=a_addr.
//  2. A reads 0x000100, q_compl with q_rdata=0xBEEF -> a_ack=1, a_rdata=0xBEEF
//     same cycle, b_rdata=0, state IDLE next cycle.
//  3. A and B request together from reset, FIXED_PRIORITY=0 -> grants A,B,A,B
//     over 4 completions; FIXED_PRIORITY=1 -> B every time.
//  4. B write 0x1234 bytesel=2'b01 to 0x0ABCDE -> q_wr_en=1, q_wdata=0x1234,
//     q_bytesel=2'b01 while granted; a_ack never asserted.
//  5. Reset asserted in GRANT_B before q_compl -> IDLE, q_access=0, no b_ack;
//     next contention grants A.
//  6. LOCK_EN: a_lock=1 for 3 A transfers, B requesting -> 3 A acks with no
//     IDLE cycle between, B granted after first ack with a_lock=0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master per-transfer arbiter in front of the SDRAM controller host port (optional lock: SDRAM_ARB_LOCK_EN)
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 25,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_access,
  input  logic [ADDR_WIDTH:1] a_addr,
  input  logic [15:0]         a_wdata,
  input  logic                a_wr_en,
  input  logic [1:0]          a_bytesel,
  input  logic                a_lock,
  output logic [15:0]         a_rdata,
  output logic                a_ack,
  input  logic                b_access,
  input  logic [ADDR_WIDTH:1] b_addr,
  input  logic [15:0]         b_wdata,
  input  logic                b_wr_en,
  input  logic [1:0]          b_bytesel,
  output logic [15:0]         b_rdata,
  output logic                b_ack,
  output logic                q_access,
  output logic [ADDR_WIDTH:1] q_addr,
  output logic [15:0]         q_wdata,
  output logic                q_wr_en,
  output logic [1:0]          q_bytesel,
  input  logic [15:0]         q_rdata,
  input  logic                q_compl,
  input  logic                q_config_done
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state_q, state_d;
  logic   last_b_q, last_b_d;
  logic   grant_a, grant_b, keep_a;
`ifdef SDRAM_ARB_LOCK_EN
  assign keep_a = a_lock;
`else
  logic unused_lock;
  assign unused_lock = a_lock;
  assign keep_a = 1'b0;
`endif
  assign grant_a = state_q == GRANT_A;
  assign grant_b = state_q == GRANT_B;
  // state and last-winner registers; last winner starts as B so A wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
    end
  end
  // arbitration in IDLE, release (or locked hold of A) on controller completion
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: if (q_config_done && (a_access || b_access))
        state_d = (a_access && b_access) ? ((FIXED_PRIORITY || !last_b_q) ? GRANT_B : GRANT_A)
                                         : (a_access ? GRANT_A : GRANT_B);
      GRANT_A: if (q_compl) begin
        last_b_d = 1'b0;
        state_d  = keep_a ? GRANT_A : IDLE;
      end
      GRANT_B: if (q_compl) begin
        last_b_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign q_access  = grant_a ? a_access  : grant_b ? b_access  : 1'b0;
  assign q_addr    = grant_a ? a_addr    : grant_b ? b_addr    : '0;
  assign q_wdata   = grant_a ? a_wdata   : grant_b ? b_wdata   : '0;
  assign q_wr_en   = grant_a ? a_wr_en   : grant_b ? b_wr_en   : 1'b0;
  assign q_bytesel = grant_a ? a_bytesel : grant_b ? b_bytesel : '0;
  assign a_ack     = q_compl & grant_a;
  assign b_ack     = q_compl & grant_b;
  assign a_rdata   = grant_a ? q_rdata : '0;
  assign b_rdata   = grant_b ? q_rdata : '0;
endmodule
